// File: rtl/decoder_3to8_seq_if.sv
// Handshake and decoded-output bundle for decoder_3to8_seq.
// The master drives encoded indices; the slave (the decoder) returns readiness and strobes.
interface decoder_3to8_seq_if;
    logic       valid_in;
    logic [2:0] encoded_in;
    logic       ready_out;
    logic [7:0] data_out;
    logic       busy;

    modport master (
        output valid_in, encoded_in,
        input  ready_out, data_out, busy
    );

    modport slave (
        input  valid_in, encoded_in,
        output ready_out, data_out, busy
    );
endinterface

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: buffers encoded indices in a FIFO and replays each
// as a one-hot strobe held for hold_cycles (0 behaves as 1) cycles.
module decoder_3to8_seq #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [HOLD_W-1:0]        hold_cycles,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_err,
    decoder_3to8_seq_if.slave        bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state, state_nxt;
    logic [2:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_load;
    logic [7:0]        data_nxt, head_onehot;
    logic              push, pop, has_data, hold_last;

    assign has_data      = (count != '0);
    assign hold_last     = (hold_cnt == HOLD_ONE);
    assign hold_load     = (hold_cycles == '0) ? HOLD_ONE : hold_cycles;
    assign head_onehot   = 8'b1 << mem[rd_ptr];
    // Readiness ignores a same-cycle pop: a full FIFO never passes data through.
    assign bus.ready_out = enable && (count < CNT_FULL);
    assign push          = bus.valid_in && bus.ready_out;
    assign bus.busy      = (state == EMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && has_data) state_nxt = EMIT;
            EMIT:    if (!enable || (hold_last && !has_data)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        data_nxt = bus.data_out;
        hold_nxt = hold_cnt;
        case (state)
            IDLE: begin
                data_nxt = '0;
                if (enable && has_data) begin
                    pop      = 1'b1;
                    data_nxt = head_onehot;
                    hold_nxt = hold_load;
                end
            end
            EMIT: begin
                if (!enable) begin
                    data_nxt = '0;
                    hold_nxt = '0;
                end else if (hold_last) begin
                    if (has_data) begin
                        pop      = 1'b1;
                        data_nxt = head_onehot;
                        hold_nxt = hold_load;
                    end else begin
                        data_nxt = '0;
                        hold_nxt = '0;
                    end
                end else begin
                    hold_nxt = hold_cnt - HOLD_ONE;
                end
            end
            default: begin
                data_nxt = '0;
                hold_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out <= '0;
            hold_cnt     <= '0;
            drop_err     <= 1'b0;
        end else begin
            bus.data_out <= data_nxt;
            hold_cnt     <= hold_nxt;
            drop_err     <= bus.valid_in && !bus.ready_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.encoded_in;
    end
endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed bench for decoder_3to8_seq: stimulus queues expected pulses (value, length)
// and a negedge monitor pops and compares them as pulses appear on data_out.
module tb_decoder_3to8_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] hold_cycles;
    logic [2:0] count;
    logic       drop_err;

    decoder_3to8_seq_if bus ();

    decoder_3to8_seq #(.DEPTH(4), .HOLD_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .hold_cycles (hold_cycles),
        .count       (count),
        .drop_err    (drop_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  val;
        int unsigned len;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  mon_val  = '0;
    int unsigned mon_rem  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [7:0] val, input int unsigned len);
        exp_t e;
        e.val = val;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget && (bus.busy || count != 3'd0); i++) tick();
        check("drain_busy", {31'b0, bus.busy}, 32'd0);
        check("drain_count", {29'b0, count}, 32'd0);
    endtask

    // Pulse lengths are carried by the scoreboard, so a held-too-long strobe shows up
    // as an unexpected new pulse and a short one as a zero inside an open pulse.
    always @(negedge clk) begin
        if (mon_rem > 0) begin
            check("pulse_hold", {24'b0, bus.data_out}, {24'b0, mon_val});
            mon_rem--;
        end else if (bus.data_out != 8'h00) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {24'b0, bus.data_out}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_start", {24'b0, bus.data_out}, {24'b0, e.val});
                mon_val = e.val;
                mon_rem = e.len - 1;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        hold_cycles    = 4'd1;
        bus.valid_in   = 1'b0;
        bus.encoded_in = 3'd0;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        check("rst_data", {24'b0, bus.data_out}, 32'h00);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_ready", {31'b0, bus.ready_out}, 32'd1);
        check("rst_drop", {31'b0, drop_err}, 32'd0);

        // Single decode, hold 3
        hold_cycles    = 4'd3;
        bus.valid_in   = 1'b1;
        bus.encoded_in = 3'd4;
        expect_pulse(8'h10, 3);
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_data", {24'b0, bus.data_out}, 32'h10);
            check("single_busy", {31'b0, bus.busy}, 32'd1);
        end
        tick();
        check("single_end", {24'b0, bus.data_out}, 32'h00);
        check("single_idle", {31'b0, bus.busy}, 32'd0);

        // Back-to-back, hold 1
        hold_cycles    = 4'd1;
        bus.valid_in   = 1'b1;
        bus.encoded_in = 3'd0;
        expect_pulse(8'h01, 1);
        tick();
        bus.encoded_in = 3'd7;
        expect_pulse(8'h80, 1);
        tick();
        check("b2b_0", {24'b0, bus.data_out}, 32'h01);
        bus.encoded_in = 3'd3;
        expect_pulse(8'h08, 1);
        tick();
        check("b2b_7", {24'b0, bus.data_out}, 32'h80);
        bus.valid_in = 1'b0;
        tick();
        check("b2b_3", {24'b0, bus.data_out}, 32'h08);
        tick();
        check("b2b_end", {24'b0, bus.data_out}, 32'h00);

        // Overflow with DEPTH 4: entries 0..4 accepted, 5 dropped
        hold_cycles  = 4'd15;
        bus.valid_in = 1'b1;
        for (int v = 0; v < 5; v++) begin
            bus.encoded_in = 3'(v);
            expect_pulse(8'h01 << v, 15);
            tick();
        end
        check("ovf_count_peak", {29'b0, count}, 32'd4);
        check("ovf_ready_low", {31'b0, bus.ready_out}, 32'd0);
        check("ovf_drop_quiet", {31'b0, drop_err}, 32'd0);
        bus.encoded_in = 3'd5;
        tick();
        bus.valid_in = 1'b0;
        check("ovf_drop_pulse", {31'b0, drop_err}, 32'd1);
        check("ovf_count_hold", {29'b0, count}, 32'd4);
        tick();
        check("ovf_drop_clear", {31'b0, drop_err}, 32'd0);
        drain(100);

        // hold_cycles = 0 behaves as 1
        hold_cycles    = 4'd0;
        bus.valid_in   = 1'b1;
        bus.encoded_in = 3'd2;
        expect_pulse(8'h04, 1);
        tick();
        bus.valid_in = 1'b0;
        tick();
        check("hold0_data", {24'b0, bus.data_out}, 32'h04);
        tick();
        check("hold0_end", {24'b0, bus.data_out}, 32'h00);

        // Enable abort on the 3rd pulse cycle; queued 1 and 6 survive
        hold_cycles    = 4'd8;
        bus.valid_in   = 1'b1;
        bus.encoded_in = 3'd5;
        expect_pulse(8'h20, 3);
        tick();
        bus.encoded_in = 3'd1;
        expect_pulse(8'h02, 2);
        tick();
        bus.encoded_in = 3'd6;
        expect_pulse(8'h40, 2);
        tick();
        bus.valid_in = 1'b0;
        tick();
        check("abort_pre", {24'b0, bus.data_out}, 32'h20);
        enable = 1'b0;
        tick();
        check("abort_data", {24'b0, bus.data_out}, 32'h00);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_count", {29'b0, count}, 32'd2);
        tick();
        check("abort_retain", {29'b0, count}, 32'd2);
        check("abort_ready", {31'b0, bus.ready_out}, 32'd0);
        hold_cycles = 4'd2;
        enable      = 1'b1;
        tick();
        check("resume_data", {24'b0, bus.data_out}, 32'h02);
        drain(20);

        // Reset while emitting 6 with three entries queued
        hold_cycles    = 4'd4;
        bus.valid_in   = 1'b1;
        bus.encoded_in = 3'd6;
        expect_pulse(8'h40, 3);
        tick();
        for (int v = 0; v < 3; v++) begin
            bus.encoded_in = 3'(v);
            tick();
        end
        bus.valid_in = 1'b0;
        check("prerst_count", {29'b0, count}, 32'd3);
        check("prerst_data", {24'b0, bus.data_out}, 32'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_data", {24'b0, bus.data_out}, 32'h00);
        check("midrst_count", {29'b0, count}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_drop", {31'b0, drop_err}, 32'd0);
        repeat (10) tick();
        check("postrst_quiet", {24'b0, bus.data_out}, 32'h00);

        hold_cycles    = 4'd1;
        bus.valid_in   = 1'b1;
        bus.encoded_in = 3'd3;
        expect_pulse(8'h08, 1);
        tick();
        bus.valid_in = 1'b0;
        tick();
        check("postrst_data", {24'b0, bus.data_out}, 32'h08);
        repeat (3) tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
